// File: rtl/gcn_div_pkg.sv
// Shared constants and state encoding for the GCN sequential divider.
// Optional rounding is enabled by defining GCN_UDIV_ROUND_EN.
package gcn_div_pkg;

   localparam int DIVIDEND_W_DEF = 19;
   localparam int DIVISOR_W_DEF  = 6;
   localparam int QUOT_W_DEF     = DIVIDEND_W_DEF - DIVISOR_W_DEF;

   // ROUND is only entered when GCN_UDIV_ROUND_EN is defined.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      ROUND = 2'd2,
      DONE  = 2'd3
   } div_state_t;

endpackage : gcn_div_pkg

// File: rtl/gcn_udiv_step.sv
// One combinational restoring-division iteration: shift the partial
// remainder left, bring in the next dividend bit, then subtract the
// divisor when it fits and emit the matching quotient bit.
module gcn_udiv_step #(
   parameter int DIVISOR_W = 6
) (
   input  logic [DIVISOR_W:0]   i_rem,
   input  logic                 i_bit,
   input  logic [DIVISOR_W-1:0] i_divisor,
   output logic [DIVISOR_W:0]   o_rem,
   output logic                 o_qbit
);

   logic [DIVISOR_W:0] w_shift;
   logic [DIVISOR_W:0] w_diff;
   logic               w_ge;

   // Trial subtraction; a set top bit means the shifted value already
   // exceeds any divisor, so it counts as "fits" as well.
   always_comb begin
      w_shift = {i_rem[DIVISOR_W-1:0], i_bit};
      w_diff  = w_shift - {1'b0, i_divisor};
      w_ge    = i_rem[DIVISOR_W] | (w_shift >= {1'b0, i_divisor});
      if (w_ge) begin
         o_rem  = w_diff;
         o_qbit = 1'b1;
      end else begin
         o_rem  = w_shift;
         o_qbit = 1'b0;
      end
   end

endmodule : gcn_udiv_step

// File: rtl/gcn_udiv_seq.sv
// Sequential unsigned radix-2 restoring divider used for GCN degree
// normalisation. One quotient bit per enabled cycle, MSB first, with
// valid/ready on both sides and a global ce stall.
// Define GCN_UDIV_ROUND_EN to add a round-to-nearest stage (one extra cycle).
module gcn_udiv_seq
   import gcn_div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF,
   parameter int QUOT_W     = DIVIDEND_W - DIVISOR_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_by_zero,
   output logic                  ovf
);

   localparam int                CNT_W    = $clog2(DIVIDEND_W);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDEND_W - 1);

   div_state_t              r_state;
   div_state_t              w_next;

   // Working registers: r_dvd shifts dividend bits out at the top and
   // quotient bits in at the bottom, so it ends holding the quotient.
   logic [DIVIDEND_W-1:0]   r_dvd;
   logic [DIVISOR_W-1:0]    r_dvs;
   logic [DIVISOR_W:0]      r_rem;
   logic [CNT_W-1:0]        r_cnt;

   // Result registers driving the outputs.
   logic                    r_out_valid;
   logic [DIVIDEND_W-1:0]   r_quot;
   logic [DIVISOR_W-1:0]    r_remo;
   logic                    r_dbz;
   logic                    r_ovf;

   logic                    w_in_ready;
   logic                    w_accept;
   logic                    w_xfer;
   logic                    w_last;
   logic                    w_dvs_zero;
   logic [DIVISOR_W:0]      w_rem_nxt;
   logic                    w_qbit;
   logic [DIVIDEND_W-1:0]   w_quot_nxt;
   logic [DIVIDEND_W-1:0]   w_res_q;
   logic [DIVISOR_W-1:0]    w_res_r;
   logic                    w_res_ovf;

   gcn_udiv_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .i_rem     (r_rem),
      .i_bit     (r_dvd[DIVIDEND_W-1]),
      .i_divisor (r_dvs),
      .o_rem     (w_rem_nxt),
      .o_qbit    (w_qbit)
   );

   // Handshake qualifiers and iteration-end detect, derived from state.
   always_comb begin
      w_in_ready = (r_state == IDLE);
      w_accept   = in_valid & w_in_ready & ce;
      w_xfer     = r_out_valid & out_ready & ce;
      w_last     = (r_cnt == CNT_LAST);
      w_dvs_zero = (divisor == DIVISOR_W'(0));
      w_quot_nxt = {r_dvd[DIVIDEND_W-2:0], w_qbit};
   end

`ifdef GCN_UDIV_ROUND_EN
   logic                    w_rnd_up;
   logic [DIVIDEND_W-1:0]   w_quot_rnd;

   // Round half up on the finished truncated result, saturating at all ones.
   always_comb begin
      w_rnd_up = ({r_rem, 1'b0} >= {2'b00, r_dvs});
      if (w_rnd_up && !(&r_dvd)) begin
         w_quot_rnd = r_dvd + DIVIDEND_W'(1);
      end else begin
         w_quot_rnd = r_dvd;
      end
      w_res_q   = w_quot_rnd;
      w_res_r   = r_rem[DIVISOR_W-1:0];
      w_res_ovf = |w_quot_rnd[DIVIDEND_W-1:QUOT_W];
   end
`else
   // Final result taken straight from the last iteration.
   always_comb begin
      w_res_q   = w_quot_nxt;
      w_res_r   = w_rem_nxt[DIVISOR_W-1:0];
      w_res_ovf = |w_quot_nxt[DIVIDEND_W-1:QUOT_W];
   end
`endif

   // FSM state register; ce low freezes the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (ce) begin
         r_state <= w_next;
      end
   end

   // FSM next-state logic.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next = w_dvs_zero ? DONE : BUSY;
            end else begin
               w_next = IDLE;
            end
         end
         BUSY: begin
            if (w_last) begin
`ifdef GCN_UDIV_ROUND_EN
               w_next = ROUND;
`else
               w_next = DONE;
`endif
            end else begin
               w_next = BUSY;
            end
         end
         ROUND: begin
            w_next = DONE;
         end
         DONE: begin
            if (w_xfer) begin
               w_next = IDLE;
            end else begin
               w_next = DONE;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   // FSM outputs: ready is a pure decode of state, the rest are registers.
   always_comb begin
      in_ready    = w_in_ready;
      out_valid   = r_out_valid;
      quotient    = r_quot;
      remainder   = r_remo;
      div_by_zero = r_dbz;
      ovf         = r_ovf;
   end

   // Working datapath: operand capture and one iteration per enabled cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dvd <= '0;
         r_dvs <= '0;
         r_rem <= '0;
         r_cnt <= '0;
      end else if (ce) begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_dvd <= dividend;
                  r_dvs <= divisor;
                  r_rem <= '0;
                  r_cnt <= '0;
               end
            end
            BUSY: begin
               r_dvd <= w_quot_nxt;
               r_rem <= w_rem_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

   // Result registers: loaded once per division, held until transferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_quot      <= '0;
         r_remo      <= '0;
         r_dbz       <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (ce) begin
         case (r_state)
            IDLE: begin
               if (w_accept && w_dvs_zero) begin
                  r_out_valid <= 1'b1;
                  r_quot      <= '1;
                  r_remo      <= '0;
                  r_dbz       <= 1'b1;
                  r_ovf       <= 1'b1;
               end
            end
`ifdef GCN_UDIV_ROUND_EN
            ROUND: begin
               r_out_valid <= 1'b1;
               r_quot      <= w_res_q;
               r_remo      <= w_res_r;
               r_dbz       <= 1'b0;
               r_ovf       <= w_res_ovf;
            end
`else
            BUSY: begin
               if (w_last) begin
                  r_out_valid <= 1'b1;
                  r_quot      <= w_res_q;
                  r_remo      <= w_res_r;
                  r_dbz       <= 1'b0;
                  r_ovf       <= w_res_ovf;
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule : gcn_udiv_seq

// File: tb/tb_gcn_udiv_seq.sv
// Directed self-checking bench for gcn_udiv_seq. Latency is counted as the
// number of clock edges after the accept edge until out_valid is seen.
module tb_gcn_udiv_seq;

   localparam int DW = 19;
   localparam int VW = 6;
   localparam int RW = DW + VW + 2;
`ifdef GCN_UDIV_ROUND_EN
   localparam int RL = 1;
`else
   localparam int RL = 0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          ce;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_by_zero;
   logic          ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   gcn_udiv_seq dut (
      .clk         (clk),
      .rst         (rst),
      .ce          (ce),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero),
      .ovf         (ovf)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands for one edge (caller guarantees the divider is idle).
   task automatic start(input logic [DW-1:0] a, input logic [VW-1:0] b);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Wait for out_valid, continuing an edge count that started at lat0.
   task automatic wait_result(input int lat0, output int lat);
      lat = lat0;
      while (out_valid !== 1'b1 && lat < 200) begin
         tick();
         lat++;
      end
      if (out_valid !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL timeout: out_valid=%b after %0d edges, required 1", out_valid, lat);
      end
   endtask

   // Full transaction: accept, wait, capture, transfer.
   task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                          output logic [RW-1:0] res, output int lat);
      start(a, b);
      wait_result(0, lat);
      res = {quotient, remainder, div_by_zero, ovf};
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      dividend = '0; divisor = '0;
      tick(); tick();
      rst = 1'b0;
      n_vec++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero, ovf} !== {1'b1, 1'b0, 27'd0}) begin
         n_err++;
         $display("FAIL reset: got rdy=%b vld=%b q=%0d r=%0d dz=%b ovf=%b, required rdy=1 and all else 0",
                  in_ready, out_valid, quotient, remainder, div_by_zero, ovf);
      end
   endtask

   task automatic test_nominal();
      logic [RW-1:0] res;
      int lat;
      out_ready = 1'b1;
      start(19'd100, 6'd7);
      wait_result(0, lat);
      res = {quotient, remainder, div_by_zero, ovf};
      tick();
      out_ready = 1'b0;
      n_vec++;
      if (res !== {19'd14, 6'd2, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL nominal_100_7: got %h, required %h", res, {19'd14, 6'd2, 2'b00});
      end
      n_vec++;
      if (lat !== 19 + RL) begin
         n_err++; $display("FAIL nominal_latency: got %0d, required %0d", lat, 19 + RL);
      end
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL nominal_after_xfer: got vld/rdy=%b%b, required 01", out_valid, in_ready);
      end
   endtask

   task automatic test_overflow();
      logic [RW-1:0] res;
      int lat;
      run_div(19'd524287, 6'd1, res, lat);
      n_vec++;
      if (res !== {19'd524287, 6'd0, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL ovf_524287_1: got %h, required %h", res, {19'd524287, 6'd0, 2'b01});
      end
      run_div(19'd8191, 6'd1, res, lat);
      n_vec++;
      if (res !== {19'd8191, 6'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL ovf_8191_1: got %h, required %h", res, {19'd8191, 6'd0, 2'b00});
      end
      run_div(19'd524287, 6'd63, res, lat);
      n_vec++;
      if (res !== {19'd8322, 6'd1, 1'b0, 1'b1}) begin
         n_err++; $display("FAIL ovf_524287_63: got %h, required %h", res, {19'd8322, 6'd1, 2'b01});
      end
      run_div(19'd0, 6'd5, res, lat);
      n_vec++;
      if (res !== {19'd0, 6'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL zero_dividend: got %h, required 0", res);
      end
      run_div(19'd63, 6'd63, res, lat);
      n_vec++;
      if (res !== {19'd1, 6'd0, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL equal_ops: got %h, required %h", res, {19'd1, 6'd0, 2'b00});
      end
      run_div(19'd12345, 6'd6, res, lat);
      n_vec++;
      if (res !== {19'(2057 + RL), 6'd3, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL div_12345_6: got %h, required %h", res, {19'(2057 + RL), 6'd3, 2'b00});
      end
   endtask

   task automatic test_div_by_zero();
      logic [RW-1:0] res;
      int lat;
      run_div(19'd1234, 6'd0, res, lat);
      n_vec++;
      if (res !== {19'd524287, 6'd0, 1'b1, 1'b1}) begin
         n_err++; $display("FAIL dbz_result: got %h, required %h", res, {19'd524287, 6'd0, 2'b11});
      end
      // Result is visible in the cycle right after the accept cycle.
      n_vec++;
      if (lat !== 0) begin
         n_err++; $display("FAIL dbz_latency: got %0d extra edges, required 0", lat);
      end
   endtask

   task automatic test_stall_backpressure();
      logic [RW-1:0] exp_res;
      int lat;
      exp_res = {19'(55 + RL), 6'd5, 1'b0, 1'b0};
      start(19'd500, 6'd9);
      lat = 0;
      repeat (5) begin tick(); lat++; end
      ce = 1'b0;
      repeat (4) begin tick(); lat++; end
      ce = 1'b1;
      wait_result(lat, lat);
      n_vec++;
      if (lat !== 23 + RL) begin
         n_err++; $display("FAIL stall_latency: got %0d, required %0d", lat, 23 + RL);
      end
      for (int i = 0; i < 5; i++) begin
         n_vec++;
         if ({out_valid, in_ready, quotient, remainder, div_by_zero, ovf} !== {1'b1, 1'b0, exp_res}) begin
            n_err++;
            $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b res=%h, required vld=1 rdy=0 res=%h",
                     i, out_valid, in_ready, {quotient, remainder, div_by_zero, ovf}, exp_res);
         end
         tick();
      end
      // ce low blocks the transfer even with out_ready high.
      ce = 1'b0; out_ready = 1'b1;
      tick();
      n_vec++;
      if (out_valid !== 1'b1) begin
         n_err++; $display("FAIL ce_blocks_xfer: got out_valid=%b, required 1", out_valid);
      end
      ce = 1'b1;
      tick();
      out_ready = 1'b0;
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL bp_release: got vld/rdy=%b%b, required 01", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_midop();
      logic [RW-1:0] res;
      int lat;
      start(19'd1000, 6'd3);
      repeat (10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero, ovf} !== {1'b1, 1'b0, 27'd0}) begin
         n_err++; $display("FAIL rst_midop: got rdy=%b vld=%b q=%0d, required rdy=1 vld=0 q=0",
                           in_ready, out_valid, quotient);
      end
      run_div(19'd1000, 6'd3, res, lat);
      n_vec++;
      if (res !== {19'd333, 6'd1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL after_rst_1000_3: got %h, required %h", res, {19'd333, 6'd1, 2'b00});
      end
      // A completed but untransferred result is dropped by reset.
      start(19'd7, 6'd2);
      wait_result(0, lat);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_err++; $display("FAIL rst_in_done: got rdy/vld=%b%b, required 10", in_ready, out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] res;
      int lat;
      dividend = 19'd40; divisor = 6'd5; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      wait_result(0, lat);
      res = {quotient, remainder, div_by_zero, ovf};
      n_vec++;
      if ({in_ready, lat, res} !== {1'b0, 32'(19 + RL), 19'd8, 6'd0, 2'b00}) begin
         n_err++; $display("FAIL b2b_first: got rdy=%b lat=%0d res=%h, required rdy=0 lat=%0d res=%h",
                           in_ready, lat, res, 19 + RL, {19'd8, 6'd0, 2'b00});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_err++; $display("FAIL b2b_xfer: got vld/rdy=%b%b, required 01", out_valid, in_ready);
      end
      tick();
      in_valid = 1'b0;
      n_vec++;
      if (in_ready !== 1'b0) begin
         n_err++; $display("FAIL b2b_reaccept: got in_ready=%b, required 0", in_ready);
      end
      wait_result(0, lat);
      res = {quotient, remainder, div_by_zero, ovf};
      n_vec++;
      if ({lat, res} !== {32'(19 + RL), 19'd8, 6'd0, 2'b00}) begin
         n_err++; $display("FAIL b2b_second: got lat=%0d res=%h, required lat=%0d res=%h",
                           lat, res, 19 + RL, {19'd8, 6'd0, 2'b00});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

`ifdef GCN_UDIV_ROUND_EN
   task automatic test_round();
      logic [RW-1:0] res;
      int lat;
      run_div(19'd100, 6'd8, res, lat);
      n_vec++;
      if ({lat, res} !== {32'd20, 19'd13, 6'd4, 2'b00}) begin
         n_err++; $display("FAIL round_100_8: got lat=%0d res=%h, required lat=20 res=%h",
                           lat, res, {19'd13, 6'd4, 2'b00});
      end
      run_div(19'd99, 6'd8, res, lat);
      n_vec++;
      if (res !== {19'd12, 6'd3, 2'b00}) begin
         n_err++; $display("FAIL round_99_8: got %h, required %h", res, {19'd12, 6'd3, 2'b00});
      end
      run_div(19'd524287, 6'd2, res, lat);
      n_vec++;
      if (res !== {19'd262144, 6'd1, 2'b01}) begin
         n_err++; $display("FAIL round_ovf: got %h, required %h", res, {19'd262144, 6'd1, 2'b01});
      end
   endtask
`endif

   initial begin
      test_reset();
      test_nominal();
      test_overflow();
      test_div_by_zero();
      test_stall_backpressure();
      test_reset_midop();
      test_back_to_back();
`ifdef GCN_UDIV_ROUND_EN
      test_round();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule : tb_gcn_udiv_seq
